// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock detector: comparator AdjustFreq codes
// and the lock FSM state encoding.
package pll_pkg;

    localparam logic [1:0] ADJ_HOLD    = 2'b00;
    localparam logic [1:0] ADJ_UP      = 2'b01;
    localparam logic [1:0] ADJ_DOWN    = 2'b10;
    localparam logic [1:0] ADJ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_SLIP    = 2'b11
    } lock_state_t;

endpackage

// File: rtl/pll_edge_counter.sv
// Rising-edge counter for one already-synchronised clock-like input.
// Counts saturate; the window total is sampled and cleared at window end.
module pll_edge_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             window_end,
    output logic [CNT_W-1:0] total,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sig_prev;
    logic             rise;
    logic [CNT_W-1:0] work;

    // total includes this cycle's edge so the last window cycle is not lost
    assign rise  = sig_in & ~sig_prev;
    assign total = (rise && (work != CNT_MAX)) ? work + 1'b1 : work;

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_prev <= 1'b0;
            work     <= '0;
            count    <= '0;
        end else begin
            sig_prev <= sig_in;
            if (window_end) begin
                work  <= '0;
                count <= total;
            end else begin
                work <= total;
            end
        end
    end

endmodule

// File: rtl/pll_lock_detector.sv
// PLL lock detector: compares reference and feedback edge counts and
// comparator activity over fixed windows and runs the lock/unlock FSM.
module pll_lock_detector #(
    parameter int WINDOW_CYCLES  = 256,
    parameter int CNT_W          = 12,
    parameter int LOCK_TOL       = 2,
    parameter int ADJ_MAX        = 8,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             RefIn,
    input  logic             FbIn,
    input  logic [1:0]       AdjustFreq,
    output logic             Locked,
    output logic             LockLost,
    output logic             WindowDone,
    output logic [CNT_W-1:0] RefCount,
    output logic [CNT_W-1:0] FbCount,
    output logic [1:0]       State
);

    import pll_pkg::*;

    localparam int                WIN_W       = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W:0]    TOL         = (CNT_W + 1)'(LOCK_TOL);
    localparam logic [CNT_W-1:0]  ACT_LIMIT   = CNT_W'(ADJ_MAX);
    localparam int                GOOD_W      = $clog2(LOCK_WINDOWS + 1);
    localparam int                BAD_W       = $clog2(UNLOCK_WINDOWS + 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_WINDOWS);
    localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(UNLOCK_WINDOWS);

    logic [WIN_W-1:0]  win_cnt;
    logic              window_end;
    logic [CNT_W-1:0]  ref_total;
    logic [CNT_W-1:0]  fb_total;
    logic [CNT_W-1:0]  act_cnt;
    logic [CNT_W-1:0]  act_total;
    logic              act_step;
    logic              illegal_q;
    logic              illegal_total;
    logic [CNT_W:0]    ref_ext;
    logic [CNT_W:0]    fb_ext;
    logic [CNT_W:0]    diff;
    logic              window_good;
    lock_state_t       state_q;
    lock_state_t       state_d;
    logic [GOOD_W-1:0] good_cnt_q;
    logic [GOOD_W-1:0] good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q;
    logic [BAD_W-1:0]  bad_cnt_d;
    logic              lost_d;
    logic              window_done_q;
    logic              lock_lost_q;

    assign window_end = (win_cnt == WIN_LAST);

    pll_edge_counter #(.CNT_W(CNT_W)) u_ref_counter (
        .clock      (Clock),
        .reset      (Reset),
        .sig_in     (RefIn),
        .window_end (window_end),
        .total      (ref_total),
        .count      (RefCount)
    );

    pll_edge_counter #(.CNT_W(CNT_W)) u_fb_counter (
        .clock      (Clock),
        .reset      (Reset),
        .sig_in     (FbIn),
        .window_end (window_end),
        .total      (fb_total),
        .count      (FbCount)
    );

    assign act_step      = (AdjustFreq != ADJ_HOLD) && (AdjustFreq != ADJ_ILLEGAL);
    assign act_total     = (act_step && (act_cnt != CNT_MAX)) ? act_cnt + 1'b1 : act_cnt;
    assign illegal_total = illegal_q | (AdjustFreq == ADJ_ILLEGAL);

    // Difference is taken one bit wider so it can never wrap
    assign ref_ext = {1'b0, ref_total};
    assign fb_ext  = {1'b0, fb_total};
    assign diff    = (ref_ext >= fb_ext) ? (ref_ext - fb_ext) : (fb_ext - ref_ext);

    assign window_good = (ref_total != '0) && (ref_total != CNT_MAX) &&
                         (fb_total != CNT_MAX) && (diff <= TOL) &&
                         (act_total <= ACT_LIMIT) && !illegal_total;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        lost_d     = 1'b0;
        if (window_end) begin
            case (state_q)
                ST_SEARCH: begin
                    if (window_good) begin
                        if (LOCK_WINDOWS == 1) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            state_d    = ST_ACQUIRE;
                            good_cnt_d = GOOD_W'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (!window_good) begin
                        state_d    = ST_SEARCH;
                        good_cnt_d = '0;
                    end else if (good_cnt_q + 1'b1 == GOOD_TARGET) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!window_good) begin
                        if (UNLOCK_WINDOWS == 1) begin
                            state_d = ST_SEARCH;
                            lost_d  = 1'b1;
                        end else begin
                            state_d   = ST_SLIP;
                            bad_cnt_d = BAD_W'(1);
                        end
                    end
                end
                ST_SLIP: begin
                    if (window_good) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q + 1'b1 == BAD_TARGET) begin
                        state_d   = ST_SEARCH;
                        bad_cnt_d = '0;
                        lost_d    = 1'b1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Working counters restart at window end so consecutive windows abut
    always_ff @(posedge Clock) begin
        if (Reset) begin
            win_cnt       <= '0;
            act_cnt       <= '0;
            illegal_q     <= 1'b0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            window_done_q <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            win_cnt       <= window_end ? '0 : win_cnt + 1'b1;
            act_cnt       <= window_end ? '0 : act_total;
            illegal_q     <= window_end ? 1'b0 : illegal_total;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            window_done_q <= window_end;
            lock_lost_q   <= lost_d;
        end
    end

    assign State      = state_q;
    assign Locked     = (state_q == ST_LOCKED) || (state_q == ST_SLIP);
    assign WindowDone = window_done_q;
    assign LockLost   = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed self-checking bench for pll_lock_detector with 16-cycle windows;
// every window's expected counts and FSM state are worked out by hand.
`timescale 1ns/1ps
module tb_pll_lock_detector;

    localparam int CNT_W = 12;

    localparam logic [1:0] S_SEARCH  = 2'b00;
    localparam logic [1:0] S_ACQUIRE = 2'b01;
    localparam logic [1:0] S_LOCKED  = 2'b10;
    localparam logic [1:0] S_SLIP    = 2'b11;

    // Square wave high on cycles 2,3,6,7,... gives 4 rising edges per window
    localparam logic [15:0] SQ     = 16'hCCCC;
    localparam logic [15:0] NONE   = 16'h0000;
    localparam logic [31:0] HOLD   = 32'h0000_0000;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             RefIn = 1'b0;
    logic             FbIn = 1'b0;
    logic [1:0]       AdjustFreq = 2'b00;
    logic             Locked;
    logic             LockLost;
    logic             WindowDone;
    logic [CNT_W-1:0] RefCount;
    logic [CNT_W-1:0] FbCount;
    logic [1:0]       State;

    int n_asserts = 0;
    int n_fail = 0;

    pll_lock_detector #(
        .WINDOW_CYCLES  (16),
        .CNT_W          (CNT_W),
        .LOCK_TOL       (2),
        .ADJ_MAX        (8),
        .LOCK_WINDOWS   (4),
        .UNLOCK_WINDOWS (2)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RefIn      (RefIn),
        .FbIn       (FbIn),
        .AdjustFreq (AdjustFreq),
        .Locked     (Locked),
        .LockLost   (LockLost),
        .WindowDone (WindowDone),
        .RefCount   (RefCount),
        .FbCount    (FbCount),
        .State      (State)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives n cycles (inputs change on negedge); mid-window pulses must stay low
    task automatic applyStimulus(input string tag, input logic [15:0] ref_pat,
                                 input logic [15:0] fb_pat, input logic [31:0] adj_pat,
                                 input int n_cycles);
        for (int i = 0; i < n_cycles; i++) begin
            RefIn      = ref_pat[i];
            FbIn       = fb_pat[i];
            AdjustFreq = adj_pat[2*i +: 2];
            @(negedge Clock);
            if (i < 15) begin
                checkOutput({tag, ".mid_done"}, 32'(WindowDone), 32'd0);
                checkOutput({tag, ".mid_lost"}, 32'(LockLost), 32'd0);
            end
        end
    endtask

    task automatic checkWindow(input string tag, input int exp_ref, input int exp_fb,
                               input logic [1:0] exp_state, input logic exp_locked,
                               input logic exp_lost);
        checkOutput({tag, ".done"}, 32'(WindowDone), 32'd1);
        checkOutput({tag, ".ref"}, 32'(RefCount), 32'(exp_ref));
        checkOutput({tag, ".fb"}, 32'(FbCount), 32'(exp_fb));
        checkOutput({tag, ".state"}, 32'(State), 32'(exp_state));
        checkOutput({tag, ".locked"}, 32'(Locked), 32'(exp_locked));
        checkOutput({tag, ".lost"}, 32'(LockLost), 32'(exp_lost));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".state"}, 32'(State), 32'(S_SEARCH));
        checkOutput({tag, ".locked"}, 32'(Locked), 32'd0);
        checkOutput({tag, ".lost"}, 32'(LockLost), 32'd0);
        checkOutput({tag, ".done"}, 32'(WindowDone), 32'd0);
        checkOutput({tag, ".ref"}, 32'(RefCount), 32'd0);
        checkOutput({tag, ".fb"}, 32'(FbCount), 32'd0);
    endtask

    initial begin
        $display("[TB] pll_lock_detector directed test start");
        repeat (2) @(negedge Clock);
        checkAllZero("reset");
        Reset = 1'b0;

        applyStimulus("w1", SQ, SQ, HOLD, 16);
        checkWindow("w1", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w2", SQ, SQ, HOLD, 16);
        checkWindow("w2", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w3", SQ, SQ, HOLD, 16);
        checkWindow("w3", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w4", SQ, SQ, HOLD, 16);
        checkWindow("w4", 4, 4, S_LOCKED, 1'b1, 1'b0);

        applyStimulus("w5_fb_dead", SQ, NONE, HOLD, 16);
        checkWindow("w5_fb_dead", 4, 0, S_SLIP, 1'b1, 1'b0);
        applyStimulus("w6_recover", SQ, SQ, HOLD, 16);
        checkWindow("w6_recover", 4, 4, S_LOCKED, 1'b1, 1'b0);
        applyStimulus("w7_bad", SQ, NONE, HOLD, 16);
        checkWindow("w7_bad", 4, 0, S_SLIP, 1'b1, 1'b0);
        applyStimulus("w8_bad", SQ, NONE, HOLD, 16);
        checkWindow("w8_bad", 4, 0, S_SEARCH, 1'b0, 1'b1);
        applyStimulus("w8b_search_bad", SQ, NONE, HOLD, 16);
        checkWindow("w8b_search_bad", 4, 0, S_SEARCH, 1'b0, 1'b0);

        applyStimulus("w9", SQ, SQ, HOLD, 16);
        checkWindow("w9", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w10", SQ, SQ, HOLD, 16);
        checkWindow("w10", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w11", SQ, SQ, HOLD, 16);
        checkWindow("w11", 4, 4, S_ACQUIRE, 1'b0, 1'b0);
        applyStimulus("w12", SQ, SQ, HOLD, 16);
        checkWindow("w12", 4, 4, S_LOCKED, 1'b1, 1'b0);

        // AdjustFreq=11 on cycle 7 only
        applyStimulus("w13_illegal", SQ, SQ, 32'h0000_C000, 16);
        checkWindow("w13_illegal", 4, 4, S_SLIP, 1'b1, 1'b0);
        applyStimulus("w14", SQ, SQ, HOLD, 16);
        checkWindow("w14", 4, 4, S_LOCKED, 1'b1, 1'b0);

        applyStimulus("w15_diff2", SQ, 16'h00CC, HOLD, 16);
        checkWindow("w15_diff2", 4, 2, S_LOCKED, 1'b1, 1'b0);
        applyStimulus("w16_diff3", SQ, 16'h000C, HOLD, 16);
        checkWindow("w16_diff3", 4, 1, S_SLIP, 1'b1, 1'b0);

        // AdjustFreq=01 on cycles 0..7 (8 cycles), then 0..8 (9 cycles)
        applyStimulus("w17_adj8", SQ, SQ, 32'h0000_5555, 16);
        checkWindow("w17_adj8", 4, 4, S_LOCKED, 1'b1, 1'b0);
        applyStimulus("w18_adj9", SQ, SQ, 32'h0001_5555, 16);
        checkWindow("w18_adj9", 4, 4, S_SLIP, 1'b1, 1'b0);
        applyStimulus("w19", SQ, SQ, HOLD, 16);
        checkWindow("w19", 4, 4, S_LOCKED, 1'b1, 1'b0);

        // Ref edges on cycles 2,6,10 and the last cycle 15
        applyStimulus("w20_last_edge", 16'h8CCC, SQ, HOLD, 16);
        checkWindow("w20_last_edge", 4, 4, S_LOCKED, 1'b1, 1'b0);

        applyStimulus("w21_bad", SQ, NONE, HOLD, 16);
        checkWindow("w21_bad", 4, 0, S_SLIP, 1'b1, 1'b0);
        applyStimulus("w22_bad", SQ, NONE, HOLD, 16);
        checkWindow("w22_bad", 4, 0, S_SEARCH, 1'b0, 1'b1);
        applyStimulus("w23", SQ, SQ, HOLD, 16);
        checkWindow("w23", 4, 4, S_ACQUIRE, 1'b0, 1'b0);

        // Reset taken on cycle 7 of an ACQUIRE window
        applyStimulus("w24_partial", SQ, SQ, HOLD, 7);
        Reset      = 1'b1;
        RefIn      = 1'b1;
        FbIn       = 1'b1;
        AdjustFreq = 2'b00;
        @(negedge Clock);
        checkAllZero("midreset");
        Reset = 1'b0;
        applyStimulus("w25_after_reset", SQ, SQ, HOLD, 16);
        checkWindow("w25_after_reset", 4, 4, S_ACQUIRE, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
